// File: rtl/pfb_snapshot_ramblk.sv
`default_nettype none
// ============================================================================
// Module   : pfb_snapshot_ramblk
// Purpose  : Triggered snapshot buffer for wide PFB/FFT fabric streams.
//            Captures a window of DATA_W words into block RAM in one-shot
//            mode (2^ADDR_W post-trigger words) or circular mode (running
//            history plus 2^(ADDR_W-1) post-trigger words).  The buffer is
//            read back through a narrower BUS_W word-addressed port.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            arm, circ           - start capture / mode (sampled with arm)
//            trig                - trigger qualifier
//            din, din_valid      - capture stream
//            bus_en, bus_addr    - readback request {row, lane}
//            bus_rd_data         - readback data, 1-cycle latency
//            busy, done          - capture status
//            trig_addr, wr_count - trigger row, words written since arm
// Revision : 1.0 - initial release
// ============================================================================
module pfb_snapshot_ramblk #(
    parameter  int DATA_W = 64,
    parameter  int ADDR_W = 10,
    parameter  int BUS_W  = 32,
    localparam int LANE_W = $clog2(DATA_W / BUS_W)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm,
    input  logic                     circ,
    input  logic                     trig,
    input  logic [DATA_W-1:0]        din,
    input  logic                     din_valid,
    input  logic                     bus_en,
    input  logic [ADDR_W+LANE_W-1:0] bus_addr,
    output logic [BUS_W-1:0]         bus_rd_data,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_W-1:0]        trig_addr,
    output logic [ADDR_W:0]          wr_count
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    // Post-trigger window lengths; c_FULL doubles as the wr_count ceiling.
    localparam logic [ADDR_W:0] c_FULL     = (ADDR_W+1)'(c_DEPTH);
    localparam logic [ADDR_W:0] c_CIRC_LEN = (ADDR_W+1)'(c_DEPTH / 2);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_WAIT    = 2'd1;
    localparam logic [1:0] c_ST_CAPTURE = 2'd2;
    localparam logic [1:0] c_ST_DONE    = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_circ;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_trig_addr;
    logic [ADDR_W:0]   r_wr_count;
    logic [ADDR_W:0]   r_post_cnt;
    logic [ADDR_W:0]   w_post_cnt_inc;
    logic [ADDR_W:0]   w_post_len;

    logic              w_we;        // RAM write this cycle
    logic              w_trig_hit;  // trigger accepted this cycle
    logic              w_post_wr;   // write belongs to the post-trigger window

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic [DATA_W-1:0] r_rd_word;
    logic [ADDR_W-1:0] w_rd_row;

    assign w_post_len     = r_circ ? c_CIRC_LEN : c_FULL;
    assign w_post_cnt_inc = r_post_cnt + 1'b1;
    assign w_rd_row       = bus_addr[ADDR_W+LANE_W-1 -: ADDR_W];

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state, write strobes and status outputs
    // Priority: rst > arm > trig.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_trig_hit  = 1'b0;
        w_post_wr   = 1'b0;

        case (r_state)
            c_ST_WAIT: begin
                if (trig) begin
                    // The trigger-cycle word is the first post-trigger word.
                    // In one-shot mode the pointer is still 0 here.
                    w_trig_hit  = 1'b1;
                    w_we        = din_valid;
                    w_post_wr   = din_valid;
                    w_state_nxt = c_ST_CAPTURE;
                end else if (r_circ) begin
                    w_we = din_valid;
                end
            end
            c_ST_CAPTURE: begin
                w_we      = din_valid;
                w_post_wr = din_valid;
            end
            default: begin
            end
        endcase

        if (w_post_wr && (w_post_cnt_inc == w_post_len)) begin
            w_state_nxt = c_ST_DONE;
        end

        // A re-arm discards whatever this cycle would have done.
        if (arm || rst) begin
            w_state_nxt = c_ST_WAIT;
            w_we        = 1'b0;
            w_trig_hit  = 1'b0;
            w_post_wr   = 1'b0;
        end

        busy = (r_state == c_ST_WAIT) || (r_state == c_ST_CAPTURE);
        done = (r_state == c_ST_DONE);
    end

    // ------------------------------------------------------------------
    // Capture datapath: pointer, counters, trigger row, latched mode
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_circ      <= 1'b0;
            r_wr_ptr    <= '0;
            r_trig_addr <= '0;
            r_wr_count  <= '0;
            r_post_cnt  <= '0;
        end else if (arm) begin
            r_circ      <= circ;
            r_wr_ptr    <= '0;
            r_trig_addr <= '0;
            r_wr_count  <= '0;
            r_post_cnt  <= '0;
        end else begin
            if (w_trig_hit) begin
                r_trig_addr <= r_wr_ptr;
            end
            if (w_we) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;    // wraps modulo depth
                if (r_wr_count != c_FULL) begin
                    r_wr_count <= r_wr_count + 1'b1;
                end
            end
            if (w_post_wr) begin
                r_post_cnt <= w_post_cnt_inc;
            end
        end
    end

    assign trig_addr = r_trig_addr;
    assign wr_count  = r_wr_count;

    // ------------------------------------------------------------------
    // Buffer RAM: write port (contents survive reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Registered read of the full row; a same-cycle write to the same row
    // returns the old contents (read-first).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_word <= '0;
        end else if (bus_en) begin
            r_rd_word <= r_mem[w_rd_row];
        end
    end

    // ------------------------------------------------------------------
    // Lane select: lane 0 is the most significant BUS_W slice of the row.
    // The lane index is registered alongside the row so the mux sits after
    // the RAM output register and latency stays at one cycle.
    // ------------------------------------------------------------------
    generate
        if (LANE_W > 0) begin : g_lane_mux
            logic [LANE_W-1:0] r_rd_lane;
            logic [BUS_W-1:0]  w_lanes [2**LANE_W];

            for (genvar gi = 0; gi < 2**LANE_W; gi++) begin : g_slice
                assign w_lanes[gi] = r_rd_word[DATA_W-1-gi*BUS_W -: BUS_W];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rd_lane <= '0;
                end else if (bus_en) begin
                    r_rd_lane <= bus_addr[LANE_W-1:0];
                end
            end

            assign bus_rd_data = w_lanes[r_rd_lane];
        end else begin : g_lane_none
            assign bus_rd_data = r_rd_word;
        end
    endgenerate

endmodule
`default_nettype wire
